// File: rtl/axim_rd_port_arbiter.sv
// Shares one AXI-master read control channel and its read data stream among
// NUM_PORTS requesters; one transfer in flight, round-robin or fixed priority.
module axim_rd_port_arbiter #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int NUM_PORTS          = 4,
  parameter bit FIXED_PRIO         = 1'b0
) (
  input  logic                                    clk,
  input  logic                                    rstn,
  input  logic [NUM_PORTS*C_M_AXI_ADDR_WIDTH-1:0] port_addr_i,
  input  logic [NUM_PORTS*C_XFER_SIZE_WIDTH-1:0]  port_size_i,
  input  logic [NUM_PORTS-1:0]                    port_start_i,
  output logic [NUM_PORTS-1:0]                    port_busy_o,
  output logic [NUM_PORTS-1:0]                    port_done_o,
  output logic [C_M_AXI_DATA_WIDTH-1:0]           port_rdata_o,
  output logic [NUM_PORTS-1:0]                    port_rvalid_o,
  output logic [NUM_PORTS-1:0]                    port_rlast_o,
  input  logic [NUM_PORTS-1:0]                    port_rready_i,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]           ctrl_raddr_offset_o,
  output logic [C_XFER_SIZE_WIDTH-1:0]            ctrl_rxfer_size_o,
  output logic                                    ctrl_rstart_o,
  input  logic                                    ctrl_rdone_i,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]           rd_tdata_i,
  input  logic                                    rd_tvalid_i,
  input  logic                                    rd_tlast_i,
  output logic                                    rd_tready_o
);

  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam logic [IDX_W:0]   NP_W     = (IDX_W+1)'(NUM_PORTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PORTS - 1);

  // GRANT is the cycle where the registered winner's size is inspected.
  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_ISSUE, S_XFER, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [NUM_PORTS-1:0]    busy_q, busy_d;
  logic [NUM_PORTS-1:0]    done_q, done_d;
  logic [IDX_W-1:0]        grant_q, grant_d;
  logic [IDX_W-1:0]        rr_q, rr_d;
  logic [IDX_W-1:0]        winner;
  logic                    any_busy;
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q [NUM_PORTS];
  logic [C_XFER_SIZE_WIDTH-1:0]  size_q [NUM_PORTS];

  always_comb begin
    logic [IDX_W:0] cand;
    winner   = '0;
    any_busy = 1'b0;
    cand     = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = FIXED_PRIO ? (IDX_W+1)'(k) : ({1'b0, rr_q} + (IDX_W+1)'(k));
      if (cand >= NP_W) cand = cand - NP_W;
      if (!any_busy && busy_q[cand[IDX_W-1:0]]) begin
        any_busy = 1'b1;
        winner   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    busy_d  = busy_q;
    done_d  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (port_start_i[i] && !busy_q[i]) busy_d[i] = 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        if (any_busy) begin
          grant_d = winner;
          state_d = S_GRANT;
        end
      end
      S_GRANT: state_d = (size_q[grant_q] == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: state_d = S_XFER;
      S_XFER:  if (ctrl_rdone_i) state_d = S_DONE;
      S_DONE: begin
        busy_d[grant_q] = 1'b0;
        if (!FIXED_PRIO) rr_d = (grant_q == LAST_IDX) ? '0 : grant_q + IDX_W'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Done is registered so it lines up with the DONE state cycle.
    if (state_d == S_DONE) done_d[grant_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      busy_q  <= '0;
      done_q  <= '0;
      grant_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (port_start_i[i] && !busy_q[i]) begin
        addr_q[i] <= port_addr_i[i*C_M_AXI_ADDR_WIDTH +: C_M_AXI_ADDR_WIDTH];
        size_q[i] <= port_size_i[i*C_XFER_SIZE_WIDTH +: C_XFER_SIZE_WIDTH];
      end
    end
  end

  always_comb begin
    ctrl_rstart_o       = (state_q == S_ISSUE);
    ctrl_raddr_offset_o = '0;
    ctrl_rxfer_size_o   = '0;
    port_rdata_o        = '0;
    port_rvalid_o       = '0;
    port_rlast_o        = '0;
    rd_tready_o         = 1'b0;
    if (state_q == S_ISSUE || state_q == S_XFER) begin
      ctrl_raddr_offset_o = addr_q[grant_q];
      ctrl_rxfer_size_o   = size_q[grant_q];
    end
    // Beats are only accepted while a transfer is actually running.
    if (state_q == S_XFER) begin
      port_rdata_o           = rd_tdata_i;
      port_rvalid_o[grant_q] = rd_tvalid_i;
      port_rlast_o[grant_q]  = rd_tvalid_i & rd_tlast_i;
      rd_tready_o            = port_rready_i[grant_q];
    end
  end

  assign port_busy_o = busy_q;
  assign port_done_o = done_q;

endmodule

// File: tb/tb_axim_rd_port_arbiter.sv
// Directed bench for axim_rd_port_arbiter: a round-robin instance (a) and a
// fixed-priority instance (b) share the same stimulus.
module tb_axim_rd_port_arbiter;
  localparam int NP = 4;

  logic            clk, rstn;
  logic [NP*32-1:0] port_addr, port_size;
  logic [NP-1:0]   port_start, port_rready;
  logic            ctrl_rdone;
  logic [31:0]     rd_tdata;
  logic            rd_tvalid, rd_tlast;

  logic [NP-1:0]   busy_a, done_a, rvalid_a, rlast_a;
  logic [31:0]     rdata_a, raddr_a, rsize_a;
  logic            rstart_a, tready_a;
  logic [NP-1:0]   busy_b, done_b, rvalid_b, rlast_b;
  logic [31:0]     rdata_b, raddr_b, rsize_b;
  logic            rstart_b, tready_b;

  int vecs = 0;
  int errs = 0;

  axim_rd_port_arbiter #(.C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32), .C_XFER_SIZE_WIDTH(32),
                         .NUM_PORTS(NP), .FIXED_PRIO(1'b0)) dut_a (
    .clk(clk), .rstn(rstn), .port_addr_i(port_addr), .port_size_i(port_size),
    .port_start_i(port_start), .port_busy_o(busy_a), .port_done_o(done_a),
    .port_rdata_o(rdata_a), .port_rvalid_o(rvalid_a), .port_rlast_o(rlast_a),
    .port_rready_i(port_rready), .ctrl_raddr_offset_o(raddr_a), .ctrl_rxfer_size_o(rsize_a),
    .ctrl_rstart_o(rstart_a), .ctrl_rdone_i(ctrl_rdone), .rd_tdata_i(rd_tdata),
    .rd_tvalid_i(rd_tvalid), .rd_tlast_i(rd_tlast), .rd_tready_o(tready_a));

  axim_rd_port_arbiter #(.C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32), .C_XFER_SIZE_WIDTH(32),
                         .NUM_PORTS(NP), .FIXED_PRIO(1'b1)) dut_b (
    .clk(clk), .rstn(rstn), .port_addr_i(port_addr), .port_size_i(port_size),
    .port_start_i(port_start), .port_busy_o(busy_b), .port_done_o(done_b),
    .port_rdata_o(rdata_b), .port_rvalid_o(rvalid_b), .port_rlast_o(rlast_b),
    .port_rready_i(port_rready), .ctrl_raddr_offset_o(raddr_b), .ctrl_rxfer_size_o(rsize_b),
    .ctrl_rstart_o(rstart_b), .ctrl_rdone_i(ctrl_rdone), .rd_tdata_i(rd_tdata),
    .rd_tvalid_i(rd_tvalid), .rd_tlast_i(rd_tlast), .rd_tready_o(tready_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic [31:0] a, input logic [31:0] s);
    port_addr[p*32 +: 32] = a;
    port_size[p*32 +: 32] = s;
  endtask

  task automatic clear_inputs();
    port_start  = '0;
    port_rready = '0;
    ctrl_rdone  = 1'b0;
    rd_tdata    = '0;
    rd_tvalid   = 1'b0;
    rd_tlast    = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    port_rready = 4'hF; rd_tvalid = 1'b1; rd_tlast = 1'b1; ctrl_rdone = 1'b1; rd_tdata = 32'hFFFF_FFFF;
    tick();
    tick();
    vecs++; if ({busy_a, done_a, busy_b, done_b} !== 16'h0) begin errs++; $display("FAIL reset_flags: busy/done a,b=%h, expected 0000", {busy_a, done_a, busy_b, done_b}); end
    vecs++; if ({rvalid_a, rlast_a, rdata_a, tready_a} !== 41'h0) begin errs++; $display("FAIL reset_data: rvalid=%b rlast=%b rdata=%h tready=%b, expected all 0", rvalid_a, rlast_a, rdata_a, tready_a); end
    vecs++; if ({rstart_a, raddr_a, rsize_a} !== 65'h0) begin errs++; $display("FAIL reset_ctrl: rstart=%b addr=%h size=%h, expected all 0", rstart_a, raddr_a, rsize_a); end
    clear_inputs();
    rstn = 1'b1;
  endtask

  task automatic test_single();
    logic [3:0] exp_l;
    do_reset();
    set_req(2, 32'h1000, 32'd64);
    port_start = 4'b0100;
    tick();
    port_start = '0;
    vecs++; if (busy_a !== 4'b0100) begin errs++; $display("FAIL single_busy: got %b, expected 0100", busy_a); end
    tick();
    vecs++; if (rstart_a !== 1'b0) begin errs++; $display("FAIL single_early_start: got %b, expected 0", rstart_a); end
    tick();
    vecs++; if ({rstart_a, raddr_a, rsize_a} !== {1'b1, 32'h1000, 32'd64}) begin errs++; $display("FAIL single_issue: rstart=%b addr=%h size=%0d, expected 1/1000/64", rstart_a, raddr_a, rsize_a); end
    tick();
    port_rready = 4'hF;
    for (int b = 0; b < 16; b++) begin
      rd_tvalid = 1'b1; rd_tdata = 32'hA000 + b; rd_tlast = (b == 15);
      #1;
      exp_l = (b == 15) ? 4'b0100 : 4'b0000;
      vecs++; if ({rvalid_a, rlast_a, rdata_a, tready_a, rstart_a} !== {4'b0100, exp_l, 32'hA000 + b, 1'b1, 1'b0}) begin errs++; $display("FAIL single_beat%0d: rvalid=%b rlast=%b rdata=%h tready=%b rstart=%b, expected 0100/%b/%h/1/0", b, rvalid_a, rlast_a, rdata_a, tready_a, rstart_a, exp_l, 32'hA000 + b); end
      tick();
    end
    rd_tvalid = 1'b0; rd_tlast = 1'b0;
    ctrl_rdone = 1'b1;
    #1;
    vecs++; if ({done_a, raddr_a} !== {4'b0000, 32'h1000}) begin errs++; $display("FAIL single_xfer_hold: done=%b addr=%h, expected 0000/1000", done_a, raddr_a); end
    tick();
    ctrl_rdone = 1'b0;
    vecs++; if ({done_a, busy_a, raddr_a} !== {4'b0100, 4'b0100, 32'h0}) begin errs++; $display("FAIL single_done: done=%b busy=%b addr=%h, expected 0100/0100/0", done_a, busy_a, raddr_a); end
    tick();
    vecs++; if ({done_a, busy_a} !== 8'h00) begin errs++; $display("FAIL single_after_done: done=%b busy=%b, expected 0000/0000", done_a, busy_a); end
  endtask

  task automatic test_rr();
    int          ord [5]      = '{0, 1, 2, 3, 1};
    logic [31:0] exp_addr [5] = '{32'h40, 32'h80, 32'hC0, 32'h100, 32'h500};
    int w;
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 32'h40 * (i + 1), 32'd4);
    port_start = 4'hF;
    tick();
    port_start = '0;
    for (int n = 0; n < 5; n++) begin
      w = 0;
      while (rstart_a !== 1'b1 && w < 20) begin tick(); w++; end
      vecs++; if (rstart_a !== 1'b1 || raddr_a !== exp_addr[n]) begin errs++; $display("FAIL rr_issue%0d: rstart=%b addr=%h, expected 1/%h", n, rstart_a, raddr_a, exp_addr[n]); end
      tick();
      ctrl_rdone = 1'b1;
      tick();
      ctrl_rdone = 1'b0;
      vecs++; if (done_a !== (4'b0001 << ord[n])) begin errs++; $display("FAIL rr_done%0d: got %b, expected port %0d", n, done_a, ord[n]); end
      if (n == 1) begin
        tick();
        set_req(1, 32'h500, 32'd4);
        port_start = 4'b0010;
        tick();
        port_start = '0;
      end
    end
  endtask

  task automatic test_fixed();
    int          ord [3]      = '{1, 0, 3};
    logic [31:0] exp_addr [3] = '{32'h100, 32'h010, 32'h300};
    int w;
    do_reset();
    set_req(3, 32'h300, 32'd8);
    set_req(1, 32'h100, 32'd8);
    port_start = 4'b1010;
    tick();
    port_start = '0;
    for (int n = 0; n < 3; n++) begin
      w = 0;
      while (rstart_b !== 1'b1 && w < 20) begin tick(); w++; end
      vecs++; if (rstart_b !== 1'b1 || raddr_b !== exp_addr[n]) begin errs++; $display("FAIL fixed_issue%0d: rstart=%b addr=%h, expected 1/%h", n, rstart_b, raddr_b, exp_addr[n]); end
      tick();
      if (n == 0) begin
        set_req(0, 32'h010, 32'd8);
        port_start = 4'b0001;
        tick();
        port_start = '0;
        vecs++; if (busy_b !== 4'b1011) begin errs++; $display("FAIL fixed_busy: got %b, expected 1011", busy_b); end
      end
      ctrl_rdone = 1'b1;
      tick();
      ctrl_rdone = 1'b0;
      vecs++; if (done_b !== (4'b0001 << ord[n])) begin errs++; $display("FAIL fixed_done%0d: got %b, expected port %0d", n, done_b, ord[n]); end
    end
  endtask

  task automatic test_zero();
    logic saw;
    do_reset();
    set_req(0, 32'h2000, 32'd0);
    port_start = 4'b0001;
    saw = rstart_a;
    for (int c = 1; c <= 4; c++) begin
      tick();
      port_start = '0;
      saw |= rstart_a;
      if (c == 2) begin
        vecs++; if (done_a !== 4'b0000) begin errs++; $display("FAIL zero_done_early: got %b, expected 0000", done_a); end
      end
      if (c == 3) begin
        vecs++; if (done_a !== 4'b0001) begin errs++; $display("FAIL zero_done: got %b, expected 0001", done_a); end
      end
      if (c == 4) begin
        vecs++; if ({busy_a, done_a} !== 8'h00) begin errs++; $display("FAIL zero_after: busy=%b done=%b, expected 0000/0000", busy_a, done_a); end
      end
    end
    vecs++; if (saw !== 1'b0) begin errs++; $display("FAIL zero_no_issue: rstart seen=%b, expected 0", saw); end
  endtask

  task automatic test_backpressure();
    int w;
    logic saw;
    do_reset();
    set_req(1, 32'h3000, 32'd32);
    port_start = 4'b0010;
    tick();
    port_start = '0;
    w = 0;
    while (rstart_a !== 1'b1 && w < 20) begin tick(); w++; end
    vecs++; if (rstart_a !== 1'b1) begin errs++; $display("FAIL bp_issue: rstart=%b after %0d cycles, expected 1", rstart_a, w); end
    ctrl_rdone = 1'b1;
    tick();
    ctrl_rdone = 1'b0;
    for (int b = 0; b < 8; b++) begin
      rd_tvalid = 1'b1; rd_tdata = 32'(b); rd_tlast = (b == 7);
      port_rready = ((b % 2) == 0) ? 4'b0010 : 4'b1101;
      if (b == 2) begin
        set_req(1, 32'hDEAD, 32'd99);
        port_start = 4'b0010;
      end else begin
        port_start = '0;
      end
      #1;
      vecs++; if ({tready_a, rvalid_a, done_a} !== {((b % 2) == 0), 4'b0010, 4'b0000}) begin errs++; $display("FAIL bp_beat%0d: tready=%b rvalid=%b done=%b, expected %b/0010/0000", b, tready_a, rvalid_a, done_a, ((b % 2) == 0)); end
      tick();
    end
    port_start = '0; rd_tvalid = 1'b0; rd_tlast = 1'b0; port_rready = '0;
    vecs++; if ({raddr_a, rsize_a} !== {32'h3000, 32'd32}) begin errs++; $display("FAIL bp_addr_unchanged: addr=%h size=%0d, expected 3000/32", raddr_a, rsize_a); end
    ctrl_rdone = 1'b1;
    tick();
    ctrl_rdone = 1'b0;
    vecs++; if (done_a !== 4'b0010) begin errs++; $display("FAIL bp_done: got %b, expected 0010", done_a); end
    set_req(1, 32'h4444, 32'd4);
    port_start = 4'b0010;
    tick();
    port_start = '0;
    vecs++; if (busy_a !== 4'b0000) begin errs++; $display("FAIL bp_start_on_done: busy=%b, expected 0000", busy_a); end
    saw = 1'b0;
    for (int c = 0; c < 4; c++) begin tick(); saw |= rstart_a; end
    vecs++; if (saw !== 1'b0) begin errs++; $display("FAIL bp_no_reissue: rstart seen=%b, expected 0", saw); end
  endtask

  task automatic test_reset_mid();
    int w;
    logic saw;
    do_reset();
    set_req(3, 32'h5000, 32'd64);
    port_start = 4'b1000;
    tick();
    port_start = '0;
    w = 0;
    while (rstart_a !== 1'b1 && w < 20) begin tick(); w++; end
    vecs++; if (rstart_a !== 1'b1) begin errs++; $display("FAIL rst_mid_issue: rstart=%b after %0d cycles, expected 1", rstart_a, w); end
    tick();
    port_rready = 4'hF;
    for (int b = 0; b < 4; b++) begin
      rd_tvalid = 1'b1; rd_tdata = 32'h77 + b;
      tick();
    end
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    #1;
    vecs++; if ({busy_a, done_a, rvalid_a, rlast_a, rstart_a, tready_a, raddr_a, rsize_a, rdata_a} !== 114'h0) begin errs++; $display("FAIL rst_mid_outputs: busy=%b done=%b rvalid=%b rstart=%b tready=%b addr=%h rdata=%h, expected all 0", busy_a, done_a, rvalid_a, rstart_a, tready_a, raddr_a, rdata_a); end
    saw = 1'b0;
    for (int c = 0; c < 4; c++) begin tick(); saw |= (|done_a) | rstart_a; end
    vecs++; if (saw !== 1'b0) begin errs++; $display("FAIL rst_mid_quiet: done/rstart seen=%b, expected 0", saw); end
    rd_tvalid = 1'b0; port_rready = '0;
    set_req(2, 32'h6000, 32'd4);
    port_start = 4'b0100;
    tick();
    port_start = '0;
    w = 0;
    while (rstart_a !== 1'b1 && w < 20) begin tick(); w++; end
    vecs++; if (rstart_a !== 1'b1 || raddr_a !== 32'h6000) begin errs++; $display("FAIL rst_mid_fresh_issue: rstart=%b addr=%h, expected 1/6000", rstart_a, raddr_a); end
    tick();
    ctrl_rdone = 1'b1;
    tick();
    ctrl_rdone = 1'b0;
    vecs++; if (done_a !== 4'b0100) begin errs++; $display("FAIL rst_mid_fresh_done: got %b, expected 0100", done_a); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_inputs();
    port_addr = '0;
    port_size = '0;
    rstn      = 1'b0;
    test_reset();
    test_single();
    test_rr();
    test_fixed();
    test_zero();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
